oled_spi_rx: RTL and testbench

- SPI receiver for the SSD1306-style 4-wire OLED link: the display side of the bus driven onto pmod_cs/pmod_mosi/pmod_sclk/pmod_dc/pmod_res.
- Oversamples the bus on the system clock and deserializes MSB-first bytes, each tagged with its D/C flag.
- Buffers bytes in a first-word-fall-through FIFO with valid/ready output and keeps per-type byte statistics.
- Used as an in-fabric loopback checker for the OLED driver and as a self-checking bench component.

---
 rtl/oled_spi_rx.sv | 183 ++++++++++++++++++
 tb/tb_oled_spi_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_rx.sv
// SSD1306-style 4-wire SPI receiver: oversamples the bus, deserializes MSB-first bytes
// tagged with D/C, and queues them in a first-word-fall-through FIFO with byte statistics.
module oled_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  input  logic                          spi_dc,
  input  logic                          oled_res_n,
  output logic [7:0]                    rx_data,
  output logic                          rx_dc,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [15:0]                   cmd_count,
  output logic [15:0]                   data_count,
  input  logic                          clr_stats
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StActive, StResetHold} state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_dc_sync, r_res_sync;
  logic                   r_sclk_prev, r_rise, r_mosi_d, r_dc_d, r_cs_d, r_res_d;
  state_e                 r_state, w_state_nxt;
  logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt, w_push_byte, r_push_byte;
  logic                   w_push, r_push, r_push_dc, w_frame_err, r_frame_err;
  logic [8:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   w_empty, w_full, w_pop, w_wr, w_drop;
  logic                   r_overflow;
  logic [15:0]            r_cmd_count, r_data_count;

  // Synchronizers reset to the idle bus: cs_n and res_n high, sclk low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_dc_sync   <= '0;
      r_res_sync  <= '1;
      r_sclk_prev <= 1'b0;
      r_rise      <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_dc_d      <= 1'b0;
      r_cs_d      <= 1'b1;
      r_res_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
      r_res_sync  <= {r_res_sync[SYNC_STAGES-2:0], oled_res_n};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      // Edge strobe and the bus bits it qualifies are registered together to stay aligned.
      r_rise      <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
      r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
      r_dc_d      <= r_dc_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_res_d     <= r_res_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_push      <= 1'b0;
      r_push_byte <= 8'd0;
      r_push_dc   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_push      <= w_push;
      r_push_byte <= w_push_byte;
      r_push_dc   <= r_dc_d;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_push_byte   = {r_shift[6:0], r_mosi_d};
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_res_d) begin
          w_state_nxt = StResetHold;
        end else if (!r_cs_d) begin
          w_state_nxt   = StActive;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      StActive: begin
        if (!r_res_d) begin
          w_state_nxt   = StResetHold;
          w_bit_cnt_nxt = 3'd0;
        end else if (r_cs_d) begin
          w_state_nxt   = StIdle;
          w_frame_err   = (r_bit_cnt != 3'd0);
          w_bit_cnt_nxt = 3'd0;
        end else if (r_rise) begin
          w_shift_nxt = w_push_byte;
          if (r_bit_cnt == 3'd7) begin
            w_push        = 1'b1;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      StResetHold: begin
        if (r_res_d) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && rx_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_push_dc, r_push_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_cmd_count  <= 16'd0;
      r_data_count <= 16'd0;
    end else if (clr_stats) begin
      r_overflow   <= 1'b0;
      r_cmd_count  <= 16'd0;
      r_data_count <= 16'd0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_wr && !r_push_dc && r_cmd_count != 16'hFFFF)  r_cmd_count  <= r_cmd_count + 16'd1;
      if (w_wr && r_push_dc && r_data_count != 16'hFFFF)  r_data_count <= r_data_count + 16'd1;
    end
  end

  assign rx_valid        = !w_empty;
  assign {rx_dc, rx_data} = w_empty ? 9'd0 : r_mem[r_rd_ptr];
  assign fifo_level      = r_level;
  assign overflow        = r_overflow;
  assign frame_err       = r_frame_err;
  assign cmd_count       = r_cmd_count;
  assign data_count      = r_data_count;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed and randomized bench for oled_spi_rx with a queue-based reference model.
module tb_oled_spi_rx;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HALF  = 5;  // 10 MHz SCLK from a 100 MHz clk

  logic        clk = 1'b0;
  logic        rst_n, spi_sclk, spi_mosi, spi_cs_n, spi_dc, oled_res_n, rx_ready, clr_stats;
  logic [7:0]  rx_data;
  logic        rx_dc, rx_valid, overflow, frame_err;
  logic [4:0]  fifo_level;
  logic [15:0] cmd_count, data_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [8:0]  q_fifo[$];
  logic [8:0]  q_got[$];
  int unsigned m_cmd = 0, m_data = 0;
  logic        m_ov = 1'b0;
  int unsigned fe_cnt = 0, fe_run = 0, fe_max = 0;

  always #5 clk = ~clk;

  oled_spi_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_dc(spi_dc), .oled_res_n(oled_res_n), .rx_data(rx_data), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level), .overflow(overflow),
    .frame_err(frame_err), .cmd_count(cmd_count), .data_count(data_count),
    .clr_stats(clr_stats)
  );

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && rx_valid && rx_ready) q_got.push_back({rx_dc, rx_data});
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && frame_err) begin
      fe_cnt++;
      fe_run++;
      if (fe_run > fe_max) fe_max = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic dc, input logic [7:0] b);
    if (q_fifo.size() < DEPTH) begin
      q_fifo.push_back({dc, b});
      if (dc) begin if (m_data < 16'hFFFF) m_data++; end
      else    begin if (m_cmd < 16'hFFFF)  m_cmd++;  end
    end else begin
      m_ov = 1'b1;
    end
  endtask

  // Sends the top n bits of b MSB first; with lat set, checks rx_valid latency on the 8th rise.
  task automatic send_bits(input logic [7:0] b, input int n, input bit lat);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wait_clk(HALF);
      spi_sclk = 1'b1;
      if (lat && i == 0) begin
        @(posedge clk);
        repeat (SYNC + 2) @(posedge clk);
        #1 chk("latency_rx_valid", rx_valid, 1);
        @(negedge clk);
      end else begin
        wait_clk(HALF);
      end
      spi_sclk = 1'b0;
    end
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    spi_dc = dc;
    send_bits(b, 8, 1'b0);
    model_push(dc, b);
  endtask

  task automatic drain_compare(input string tag);
    int unsigned n;
    rx_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && rx_valid; i++) @(negedge clk);
    rx_ready = 1'b0;
    wait_clk(2);
    chk({tag, "_drained"}, rx_valid, 0);
    chk({tag, "_pop_count"}, q_got.size(), q_fifo.size());
    n = (q_got.size() < q_fifo.size()) ? q_got.size() : q_fifo.size();
    for (int i = 0; i < n; i++) chk({tag, "_pop"}, q_got[i], q_fifo[i]);
    q_got.delete();
    q_fifo.delete();
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    m_cmd = 0; m_data = 0; m_ov = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_cmd_count"}, cmd_count, m_cmd);
    chk({tag, "_data_count"}, data_count, m_data);
    chk({tag, "_overflow"}, overflow, m_ov);
  endtask

  initial begin
    int unsigned fe0, nb;
    logic [7:0]  rb;
    logic        rdc;
    rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; spi_dc = 1'b0;
    oled_res_n = 1'b1; rx_ready = 1'b0; clr_stats = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(100);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_fifo_level", fifo_level, 0);
    chk("reset_rx_data", {rx_dc, rx_data}, 0);
    chk("reset_frame_err", frame_err, 0);
    chk_stats("reset");

    // Single command byte with latency check
    spi_cs_n = 1'b0; spi_dc = 1'b0;
    wait_clk(4 * HALF);
    send_bits(8'hAF, 8, 1'b1);
    model_push(1'b0, 8'hAF);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(20);
    chk("cmd_level", fifo_level, 1);
    chk("cmd_head", {rx_dc, rx_data}, {1'b0, 8'hAF});
    chk_stats("cmd");
    chk("cmd_no_frame_err", fe_cnt, 0);
    drain_compare("cmd");

    // Back-to-back data bytes drained live
    rx_ready = 1'b1;
    spi_cs_n = 1'b0;
    wait_clk(4 * HALF);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'hFF);
    send_byte(1'b1, 8'h5A);
    spi_cs_n = 1'b1;
    wait_clk(20);
    chk_stats("b2b");
    chk("b2b_no_frame_err", fe_cnt, 0);
    drain_compare("b2b");

    // Partial byte aborted by CS
    fe0 = fe_cnt;
    spi_cs_n = 1'b0;
    wait_clk(4 * HALF);
    send_bits(8'hB7, 5, 1'b0);
    spi_cs_n = 1'b1;
    wait_clk(20);
    chk("partial_frame_err_pulses", fe_cnt - fe0, 1);
    chk("partial_frame_err_width", fe_max, 1);
    chk("partial_level", fifo_level, 0);

    // Partial byte aborted by display reset, then a good byte
    fe0 = fe_cnt;
    spi_cs_n = 1'b0;
    wait_clk(4 * HALF);
    send_bits(8'hB7, 5, 1'b0);
    oled_res_n = 1'b0;
    wait_clk(10);
    oled_res_n = 1'b1;
    wait_clk(10);
    send_byte(1'b0, 8'h3C);
    spi_cs_n = 1'b1;
    wait_clk(20);
    chk("res_no_frame_err", fe_cnt - fe0, 0);
    chk("res_level", fifo_level, 1);
    chk_stats("res");
    drain_compare("res");

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      spi_cs_n = 1'b0;
      wait_clk(4 * HALF);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        rb  = 8'($urandom);
        rdc = 1'($urandom_range(0, 1));
        send_byte(rdc, rb);
      end
      spi_cs_n = 1'b1;
      wait_clk(20);
    end
    chk("rand_level", fifo_level, q_fifo.size());
    chk_stats("rand");
    drain_compare("rand");

    // Overflow with rx_ready held low
    clear_stats();
    chk_stats("clr1");
    spi_cs_n = 1'b0;
    wait_clk(4 * HALF);
    for (int i = 1; i <= DEPTH + 2; i++) send_byte(1'b1, 8'(i));
    spi_cs_n = 1'b1;
    wait_clk(20);
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_head", {rx_dc, rx_data}, {1'b1, 8'h01});
    chk("ovf_flag", overflow, 1);
    chk_stats("ovf");
    drain_compare("ovf");
    clear_stats();
    chk_stats("clr2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
